pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch sequencer that owns the program counter and drives the instruction-memory request port. It replaces the free-running PC increment with a controlled schedule: reset start-up, a valid/ack handshake with instruction memory, pipeline stall hold, and prioritised redirects (flush, then branch). It sits at the front of the IF stage and feeds the IF/ID register with `fetch_valid`/`fetch_pc`.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `EXC_VECTOR`, 32'h0000_0020, redirect target for misaligned targets (only with `PC_ALIGN_CHK_EN`)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall`  in  1  pipeline stall, suppresses issue of new fetches
- `br_valid`  in  1  branch redirect request, single-cycle
- `br_target`  in  32  branch target address
- `flush`  in  1  exception/flush redirect request, single-cycle
- `flush_pc`  in  32  flush target address
- `if_ack`  in  1  instruction memory accepted current request
- `ce`  out  1  instruction-memory chip enable
- `if_req`  out  1  fetch request valid
- `if_addr`  out  32  fetch address, equal to `pc`
- `pc`  out  32  current program counter
- `fetch_valid`  out  1  one-cycle pulse: acked fetch is valid for decode
- `fetch_pc`  out  32  address of the instruction flagged by `fetch_valid`
- `misalign`  out  1  one-cycle pulse on misaligned redirect target

## Operation
- States: OFF, REQ, HOLD. `ce` = (state != OFF). `if_req` = (state == REQ).
- Reset (`rst`=0, any time): state OFF, `pc`=RESET_PC, pending-redirect register cleared, all other outputs 0. Any outstanding request is abandoned.
- OFF: on the first rising edge with `rst`=1, go to REQ.
- REQ: `if_req`/`if_addr` held stable until `if_ack`; `stall` never withdraws an unacked request.
  - Redirect without `if_ack`: latch into pending register; `flush` overwrites a pending branch; `br_valid` does not overwrite a pending flush.
  - `if_ack` with a pending or same-cycle redirect: discard the returned word (`fetch_valid`=0), `pc`<=redirect target (priority: same-cycle flush, pending flush, same-cycle branch, pending branch), clear pending.
  - `if_ack` without redirect: `fetch_valid`=1, `fetch_pc`=`pc`, `pc`<=`pc`+4.
  - After an ack: go to HOLD if `stall`=1, else stay in REQ.
- HOLD: `if_req`=0, `pc` held. A redirect loads `pc` directly (flush wins over branch). `stall`=0 returns to REQ on the next edge.
- Arithmetic: `pc`+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Target alignment without the macro: target[1:0] forced to 2'b00.

## Timing
- `ce` and `if_req` rise on the first edge after `rst` deasserts; `if_addr`=RESET_PC in that cycle.
- Zero-wait memory (`if_ack` tied 1): one fetch per cycle, `fetch_valid` continuous, `pc` advances 4 per cycle.
- `fetch_valid`/`fetch_pc` are registered: they assert in the cycle after the acking edge and last one cycle.
- Redirect-to-fetch latency: a new target appears on `if_addr` in the cycle after the edge on which the redirect is applied.
- Stall entered with no ack outstanding: at most one further fetch completes. `if_req` drops in the cycle after the acking edge.

## Configuration
- `PC_ALIGN_CHK_EN` defined: a redirect target with bits[1:0] != 0 is not applied. `pc`<=EXC_VECTOR and `misalign` pulses one cycle, registered with the `pc` update.
- Not defined: target bits[1:0] are silently cleared and `misalign` is tied to 0.

## Test plan
- Reset release, `if_ack`=1, no stall: `if_addr` sequence 0x0, 0x4, 0x8; `fetch_pc` follows one cycle later; `ce`=0 while `rst`=0.
- `if_ack` low for 3 cycles at `pc`=0x10: `if_addr` stays 0x10 and no `fetch_valid` until ack; next address is 0x14.
- `br_valid`, target 0x100, during an unacked request at 0x20, then ack: the 0x20 word is discarded and the next `if_addr` is 0x100. Same case with `flush` to 0x200 one cycle later: next address is 0x200.
- `stall`=1 in REQ with ack: `if_req` drops, `pc` holds; `br_valid` to 0x40 in HOLD; `stall`=0 resumes fetch at 0x40.
- `pc`=0xFFFF_FFFC acked: next `if_addr` is 0x0000_0000.
- Branch target 0x102: with `PC_ALIGN_CHK_EN`, `misalign`=1 and `pc`=0x20; without it, `pc`=0x100.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction-memory valid/ack port, handles stall and redirects.
// Optional macro PC_ALIGN_CHK_EN: misaligned redirect targets go to EXC_VECTOR and pulse misalign.
//
// state | meaning
// OFF   | in reset / first cycle after release, no request
// REQ   | request at pc outstanding until if_ack
// HOLD  | pipeline stalled, no request, pc held
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        if_ack,
  output logic        ce,
  output logic        if_req,
  output logic [31:0] if_addr,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        misalign
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_pend_vld;
  logic        r_pend_flush;
  logic [31:0] r_pend_tgt;
  logic        r_fetch_valid;
  logic [31:0] r_fetch_pc;
  logic        r_misalign;

  logic        w_redir_vld;
  logic [31:0] w_redir_tgt;
  logic        w_tgt_bad;
  logic [31:0] w_new_pc;

  // Redirect priority: same-cycle flush, pending flush, same-cycle branch, pending branch.
  always_comb begin
    w_redir_vld = 1'b1;
    w_redir_tgt = flush_pc;
    if (flush) begin
      w_redir_tgt = flush_pc;
    end else if (r_pend_vld && r_pend_flush) begin
      w_redir_tgt = r_pend_tgt;
    end else if (br_valid) begin
      w_redir_tgt = br_target;
    end else if (r_pend_vld) begin
      w_redir_tgt = r_pend_tgt;
    end else begin
      w_redir_vld = 1'b0;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  assign w_tgt_bad = |w_redir_tgt[1:0];
  assign w_new_pc  = w_tgt_bad ? EXC_VECTOR : w_redir_tgt;
`else
  assign w_tgt_bad = 1'b0;
  assign w_new_pc  = w_redir_tgt & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_OFF;
      r_pc          <= RESET_PC;
      r_pend_vld    <= 1'b0;
      r_pend_flush  <= 1'b0;
      r_pend_tgt    <= 32'h0;
      r_fetch_valid <= 1'b0;
      r_fetch_pc    <= 32'h0;
      r_misalign    <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b0;
      r_misalign    <= 1'b0;
      case (r_state)
        ST_OFF: r_state <= ST_REQ;
        ST_REQ: begin
          if (if_ack) begin
            if (w_redir_vld) begin
              r_pc       <= w_new_pc;
              r_misalign <= w_tgt_bad;
            end else begin
              r_fetch_valid <= 1'b1;
              r_fetch_pc    <= r_pc;
              r_pc          <= r_pc + 32'd4;
            end
            r_pend_vld   <= 1'b0;
            r_pend_flush <= 1'b0;
            r_state      <= stall ? ST_HOLD : ST_REQ;
          end else if (flush) begin
            r_pend_vld   <= 1'b1;
            r_pend_flush <= 1'b1;
            r_pend_tgt   <= flush_pc;
          end else if (br_valid && !(r_pend_vld && r_pend_flush)) begin
            r_pend_vld   <= 1'b1;
            r_pend_flush <= 1'b0;
            r_pend_tgt   <= br_target;
          end
        end
        ST_HOLD: begin
          if (w_redir_vld) begin
            r_pc       <= w_new_pc;
            r_misalign <= w_tgt_bad;
          end
          if (!stall) r_state <= ST_REQ;
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign ce          = (r_state != ST_OFF);
  assign if_req      = (r_state == ST_REQ);
  assign if_addr     = r_pc;
  assign pc          = r_pc;
  assign fetch_valid = r_fetch_valid;
  assign fetch_pc    = r_fetch_pc;
  assign misalign    = r_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: start-up, wait states, pending redirects, stall/HOLD, wrap, alignment, async reset.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        if_ack;
  logic        ce;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .flush(flush), .flush_pc(flush_pc), .if_ack(if_ack), .ce(ce), .if_req(if_req),
    .if_addr(if_addr), .pc(pc), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = 32'h0;
    flush = 1'b0; flush_pc = 32'h0; if_ack = 1'b1;
    tick; tick;
    chk("rst_ce", {31'h0, ce}, 32'h0);
    chk("rst_req", {31'h0, if_req}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'h0, fetch_valid}, 32'h0);

    rst = 1'b1;
    tick;
    chk("e1_ce", {31'h0, ce}, 32'h1);
    chk("e1_req", {31'h0, if_req}, 32'h1);
    chk("e1_addr", if_addr, 32'h0);
    chk("e1_fv", {31'h0, fetch_valid}, 32'h0);
    tick;
    chk("e2_addr", if_addr, 32'h4);
    chk("e2_fv", {31'h0, fetch_valid}, 32'h1);
    chk("e2_fpc", fetch_pc, 32'h0);
    tick;
    chk("e3_addr", if_addr, 32'h8);
    chk("e3_fpc", fetch_pc, 32'h4);
    tick; tick;
    chk("e5_addr", if_addr, 32'h10);

    if_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wait_addr", if_addr, 32'h10);
      chk("wait_fv", {31'h0, fetch_valid}, 32'h0);
      chk("wait_req", {31'h0, if_req}, 32'h1);
    end
    if_ack = 1'b1;
    tick;
    chk("ack_addr", if_addr, 32'h14);
    chk("ack_fv", {31'h0, fetch_valid}, 32'h1);
    chk("ack_fpc", fetch_pc, 32'h10);
    tick; tick; tick;
    chk("pre_br_addr", if_addr, 32'h20);

    if_ack = 1'b0; br_valid = 1'b1; br_target = 32'h100;
    tick;
    chk("br_pend_addr", if_addr, 32'h20);
    br_valid = 1'b0; if_ack = 1'b1;
    tick;
    chk("br_addr", if_addr, 32'h100);
    chk("br_discard_fv", {31'h0, fetch_valid}, 32'h0);

    if_ack = 1'b0; br_valid = 1'b1; br_target = 32'h180;
    tick;
    br_valid = 1'b0; flush = 1'b1; flush_pc = 32'h200;
    tick;
    chk("fl_pend_addr", if_addr, 32'h100);
    flush = 1'b0; if_ack = 1'b1; br_valid = 1'b1; br_target = 32'h400;
    tick;
    chk("fl_addr", if_addr, 32'h200);
    chk("fl_discard_fv", {31'h0, fetch_valid}, 32'h0);

    br_valid = 1'b0; stall = 1'b1;
    tick;
    chk("st_req", {31'h0, if_req}, 32'h0);
    chk("st_ce", {31'h0, ce}, 32'h1);
    chk("st_pc", pc, 32'h204);
    chk("st_fpc", fetch_pc, 32'h200);
    tick;
    chk("hold_pc", pc, 32'h204);
    chk("hold_fv", {31'h0, fetch_valid}, 32'h0);
    br_valid = 1'b1; br_target = 32'h40;
    tick;
    chk("hold_br_pc", pc, 32'h40);
    chk("hold_br_req", {31'h0, if_req}, 32'h0);
    br_valid = 1'b0; stall = 1'b0;
    tick;
    chk("resume_req", {31'h0, if_req}, 32'h1);
    chk("resume_addr", if_addr, 32'h40);
    tick;
    chk("resume_next", if_addr, 32'h44);
    chk("resume_fpc", fetch_pc, 32'h40);

    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    tick;
    chk("wrap_pre", if_addr, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick;
    chk("wrap_addr", if_addr, 32'h0);
    chk("wrap_fpc", fetch_pc, 32'hFFFF_FFFC);

    br_valid = 1'b1; br_target = 32'h102;
    tick;
`ifdef PC_ALIGN_CHK_EN
    chk("mis_pc", pc, 32'h20);
    chk("mis_flag", {31'h0, misalign}, 32'h1);
`else
    chk("mis_pc", pc, 32'h100);
    chk("mis_flag", {31'h0, misalign}, 32'h0);
`endif
    br_valid = 1'b0;
    tick;
    chk("mis_pulse_end", {31'h0, misalign}, 32'h0);

    #2 rst = 1'b0;
    #1;
    chk("async_ce", {31'h0, ce}, 32'h0);
    chk("async_req", {31'h0, if_req}, 32'h0);
    chk("async_pc", pc, 32'h0);
    chk("async_fv", {31'h0, fetch_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
